// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one i2c_fsm write engine among NUM_REQ requesters.
// Accepts one (addr, data) per handshake, issues it to the engine, and reports done or timeout.
// ACK_TIMEOUT must be at least 2.
module i2c_req_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned ADDR_WIDTH  = 7,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic                             clk,
   input  logic                             arst,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
   output logic [NUM_REQ-1:0]               req_done,
   output logic                             fsm_start,
   output logic [ADDR_WIDTH-1:0]            fsm_addr,
   output logic [DATA_WIDTH-1:0]            fsm_data,
   input  logic                             fsm_ready,
   output logic                             busy,
   output logic [$clog2(NUM_REQ)-1:0]       grant_id,
   output logic                             timeout_err
);

   localparam int unsigned ID_W  = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_DONE
   } state_t;

   state_t                state;
   logic [ID_W-1:0]       rr_ptr;
   logic [CNT_W-1:0]      cnt;
   logic [ID_W-1:0]       winner;
   logic                  handshake;
   logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
   logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

   // (base + off) mod NUM_REQ for base, off < NUM_REQ; a single subtract is enough
   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return ID_W'(s);
   endfunction

   // Unpack the per-requester address/data slices
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // First valid requester at or after rr_ptr; scanned backwards so the nearest offset wins
   always_comb begin
      winner = rr_ptr;
      for (int unsigned k = NUM_REQ; k > 0; k--) begin
         if (req_valid[wrap_add(rr_ptr, k - 1)]) winner = wrap_add(rr_ptr, k - 1);
      end
   end

   assign handshake = (state == S_IDLE) && fsm_ready && (|req_valid);

   // Combinational one-hot accept strobe to the winner
   always_comb begin
      req_ready         = '0;
      req_ready[winner] = handshake;
   end

   // Sequencer: grant, issue start, wait for engine to go busy then idle again
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state       <= S_IDLE;
         rr_ptr      <= '0;
         grant_id    <= '0;
         fsm_addr    <= '0;
         fsm_data    <= '0;
         fsm_start   <= 1'b0;
         req_done    <= '0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
         cnt         <= '0;
      end else begin
         fsm_start   <= 1'b0;
         req_done    <= '0;
         timeout_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (handshake) begin
                  fsm_addr  <= addr_arr[winner];
                  fsm_data  <= data_arr[winner];
                  grant_id  <= winner;
                  fsm_start <= 1'b1;
                  busy      <= 1'b1;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt   <= '0;
               state <= S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (!fsm_ready) begin
                  state <= S_WAIT_DONE;
               end else if (cnt == CNT_W'(ACK_TIMEOUT - 2)) begin
                  // this increment would reach ACK_TIMEOUT-1: give up on the engine
                  timeout_err <= 1'b1;
                  rr_ptr      <= wrap_add(grant_id, 1);
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_WAIT_DONE: begin
               if (fsm_ready) begin
                  req_done[grant_id] <= 1'b1;
                  rr_ptr             <= wrap_add(grant_id, 1);
                  busy               <= 1'b0;
                  state              <= S_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Testbench for i2c_req_arbiter: transaction-level reference model with a scoreboard.
// The driver predicts grants and completion cycles; a negedge monitor compares DUT outputs.
module tb_i2c_req_arbiter;

   localparam int unsigned NUM_REQ     = 4;
   localparam int unsigned ADDR_WIDTH  = 7;
   localparam int unsigned DATA_WIDTH  = 8;
   localparam int unsigned ACK_TIMEOUT = 16;
   localparam int unsigned ID_W        = $clog2(NUM_REQ);

   logic                          clk  = 1'b0;
   logic                          arst = 1'b1;
   logic [NUM_REQ-1:0]            req_valid = '0;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr = '0;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data = '0;
   logic [NUM_REQ-1:0]            req_done;
   logic                          fsm_start;
   logic [ADDR_WIDTH-1:0]         fsm_addr;
   logic [DATA_WIDTH-1:0]         fsm_data;
   logic                          fsm_ready = 1'b1;
   logic                          busy;
   logic [ID_W-1:0]               grant_id;
   logic                          timeout_err;

   i2c_req_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk(clk), .arst(arst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
      .req_done(req_done), .fsm_start(fsm_start), .fsm_addr(fsm_addr), .fsm_data(fsm_data),
      .fsm_ready(fsm_ready), .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } item_t;

   typedef struct {
      int                    cyc;
      int                    id;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } start_t;

   typedef struct {
      int cyc;
      int id;
   } ev_t;

   // Requester transaction queues and expected-event scoreboards
   item_t  rq [NUM_REQ][$];
   start_t q_start[$];
   ev_t    q_done[$];
   ev_t    q_to[$];

   // Reference model state (cycle numbers are absolute)
   int  cyc = 0;
   int  m_ptr = 0, m_ptr_next = 0;
   int  free_at = 0, busy_from = 0;
   int  low_from = 0, low_to = 0;
   int  hs_id = -1;
   bit  force_low = 1'b0;
   int  ov_mode = -1, ov_d = 0, ov_l = 1;
   logic [NUM_REQ-1:0] exp_ready = '0;
   bit  exp_busy = 1'b0;
   bit  mon_en = 1'b0;

   int pass_cnt = 0;
   int check_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic bit any_pending();
      for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic push_item(input int r, input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
      item_t it;
      it.addr = a;
      it.data = d;
      rq[r].push_back(it);
   endtask

   task automatic push_rand(input int r);
      push_item(r, ADDR_WIDTH'($urandom), DATA_WIDTH'($urandom));
   endtask

   // One clock cycle: drive inputs, then predict this cycle's accept and any future events
   task automatic step();
      int     w;
      int     mode, d, l;
      start_t s;
      ev_t    e;
      @(posedge clk);
      #1;
      cyc++;
      if (hs_id >= 0) begin
         void'(rq[hs_id].pop_front());
         hs_id = -1;
      end
      if (cyc == free_at) m_ptr = m_ptr_next;
      fsm_ready = !force_low && !(cyc >= low_from && cyc < low_to);
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i] = (rq[i].size() != 0);
         if (rq[i].size() != 0) begin
            req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = rq[i][0].addr;
            req_data[i*DATA_WIDTH +: DATA_WIDTH] = rq[i][0].data;
         end else begin
            req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'($urandom);
            req_data[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom);
         end
      end
      exp_busy  = (cyc >= busy_from) && (cyc < free_at);
      exp_ready = '0;
      if (cyc >= free_at && fsm_ready && (|req_valid)) begin
         w = -1;
         for (int k = 0; k < NUM_REQ; k++)
            if (w < 0 && req_valid[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
         exp_ready[w] = 1'b1;
         hs_id        = w;
         s.cyc  = cyc + 1;
         s.id   = w;
         s.addr = rq[w][0].addr;
         s.data = rq[w][0].data;
         q_start.push_back(s);
         busy_from = cyc + 1;
         if (ov_mode >= 0) begin
            mode = ov_mode; d = ov_d; l = ov_l;
         end else begin
            mode = ($urandom_range(0, 5) == 0) ? 0 : 1;
            d    = int'($urandom_range(0, 5));
            l    = int'($urandom_range(1, 8));
         end
         e.id = w;
         if (mode == 0) begin
            low_from = 0;
            low_to   = 0;
            free_at  = cyc + int'(ACK_TIMEOUT) + 1;
            e.cyc    = free_at;
            q_to.push_back(e);
         end else begin
            low_from = cyc + 2 + d;
            low_to   = low_from + l;
            free_at  = low_to + 1;
            e.cyc    = free_at;
            q_done.push_back(e);
         end
         m_ptr_next = (w + 1) % NUM_REQ;
      end
   endtask

   // Assert reset (asynchronously), check immediate reset values, release
   task automatic do_reset();
      mon_en = 1'b0;
      arst   = 1'b0;
      req_valid = '0;
      fsm_ready = 1'b1;
      force_low = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
      q_start.delete();
      q_done.delete();
      q_to.delete();
      m_ptr = 0; m_ptr_next = 0; free_at = 0; busy_from = 0;
      low_from = 0; low_to = 0; hs_id = -1; ov_mode = -1;
      exp_ready = '0; exp_busy = 1'b0;
      #2;
      check("rst_busy",        32'(busy),        32'(0));
      check("rst_fsm_start",   32'(fsm_start),   32'(0));
      check("rst_req_done",    32'(req_done),    32'(0));
      check("rst_timeout_err", 32'(timeout_err), 32'(0));
      check("rst_grant_id",    32'(grant_id),    32'(0));
      check("rst_fsm_addr",    32'(fsm_addr),    32'(0));
      check("rst_fsm_data",    32'(fsm_data),    32'(0));
      check("rst_req_ready",   32'(req_ready),   32'(0));
      repeat (2) @(posedge clk);
      #1;
      arst   = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic drain(input int limit);
      int n;
      n = 0;
      while (n < limit && (cyc < free_at || any_pending() ||
                           q_start.size() != 0 || q_done.size() != 0 || q_to.size() != 0)) begin
         step();
         n++;
      end
      check("drain_bound", 32'(n < limit), 32'(1));
   endtask

   // Scoreboard monitor: every cycle, compare strobes and pop expected events due now
   always @(negedge clk) begin
      start_t s;
      ev_t    e;
      if (mon_en && arst) begin
         check("req_ready", 32'(req_ready), 32'(exp_ready));
         check("busy", 32'(busy), 32'(exp_busy));
         if (q_start.size() != 0 && q_start[0].cyc == cyc) begin
            s = q_start.pop_front();
            check("start_pulse", 32'(fsm_start), 32'(1));
            check("start_addr",  32'(fsm_addr),  32'(s.addr));
            check("start_data",  32'(fsm_data),  32'(s.data));
            check("start_grant", 32'(grant_id),  32'(s.id));
         end else begin
            check("start_idle", 32'(fsm_start), 32'(0));
         end
         if (q_done.size() != 0 && q_done[0].cyc == cyc) begin
            e = q_done.pop_front();
            check("done_vec",   32'(req_done), 32'(1) << e.id);
            check("done_grant", 32'(grant_id), 32'(e.id));
         end else begin
            check("done_idle", 32'(req_done), 32'(0));
         end
         if (q_to.size() != 0 && q_to[0].cyc == cyc) begin
            e = q_to.pop_front();
            check("timeout_pulse", 32'(timeout_err), 32'(1));
         end else begin
            check("timeout_idle", 32'(timeout_err), 32'(0));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      #1;
      do_reset();

      // Single request from requester 2, engine busy for 20 cycles
      ov_mode = 1; ov_d = 0; ov_l = 20;
      push_item(2, 7'h2A, 8'hC3);
      drain(100);

      // All four requesters held high: strict rotation 0,1,2,3,0,1,2,3
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
         push_rand(i);
         push_rand(i);
      end
      drain(400);

      // Wrap-around: serve 2, then 3 and 0 request together
      do_reset();
      push_rand(2);
      drain(100);
      push_rand(3);
      push_rand(0);
      drain(200);

      // Engine never leaves ready: timeout, then pointer advances past requester 1
      ov_mode = 0;
      push_rand(1);
      drain(100);
      ov_mode = -1;
      push_rand(1);
      push_rand(2);
      drain(200);

      // Engine not ready: no grant until it rises
      force_low = 1'b1;
      push_rand(1);
      repeat (5) step();
      force_low = 1'b0;
      drain(100);

      // Reset during WAIT_DONE aborts silently
      do_reset();
      ov_mode = 1; ov_d = 0; ov_l = 12;
      push_rand(1);
      repeat (6) step();
      do_reset();
      repeat (20) step();

      // Randomized traffic with occasional withdrawals
      do_reset();
      for (int t = 0; t < 3000; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            int r;
            r = int'($urandom_range(0, NUM_REQ - 1));
            if (rq[r].size() < 3) push_rand(r);
         end
         if ($urandom_range(0, 63) == 0) begin
            int r;
            r = int'($urandom_range(0, NUM_REQ - 1));
            if (r != hs_id) rq[r].delete();
         end
         step();
      end
      drain(1000);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares one i2c_fsm write engine among NUM_REQ independent requesters. It accepts one (addr, data) transaction per valid/ready handshake and latches it. It then drives the fsm start/addr/data inputs, tracks the fsm ready line through the transfer, and returns a per-requester done pulse. It sits between the AXI-Stream-side command sources and i2c_fsm.

Parameters:
NUM_REQ, 4, number of requesters (2..8, need not be a power of two)
ADDR_WIDTH, 7, I2C slave address width
DATA_WIDTH, 8, payload width
ACK_TIMEOUT, 16, max cycles to wait for fsm_ready to drop after fsm_start

Ports:
clk  in  1  system clock, rising edge
arst  in  1  asynchronous reset, active-low
req_valid  in  NUM_REQ  per-requester transaction request
req_ready  out  NUM_REQ  one-hot accept strobe, combinational
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i in slice [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data  in  NUM_REQ*DATA_WIDTH  packed payloads; same slicing as req_addr
req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester
fsm_start  out  1  start pulse to i2c_fsm
fsm_addr  out  ADDR_WIDTH  latched address to i2c_fsm
fsm_data  out  DATA_WIDTH  latched data to i2c_fsm
fsm_ready  in  1  i2c_fsm idle indicator
busy  out  1  high whenever state != IDLE
grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester
timeout_err  out  1  one-cycle pulse when fsm fails to leave ready

Behaviour:
- Reset values (arst low, immediate): state IDLE, rr_ptr 0, grant_id 0, fsm_addr 0, fsm_data 0, fsm_start 0, req_done 0, timeout_err 0, busy 0, timeout counter 0. req_ready is 0 in reset by construction.
- Winner selection (combinational): first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ.
- req_ready[winner] = (state==IDLE) && fsm_ready && any req_valid. All other req_ready bits are 0.
- A handshake is req_valid[i] && req_ready[i] at a rising edge.
- FSM states:
  - IDLE: on handshake, latch req_addr/req_data of the winner into fsm_addr/fsm_data and set grant_id=winner -> ISSUE. If fsm_ready=0, no grant is made and the state stays IDLE.
  - ISSUE: fsm_start=1 for exactly this one cycle; clear the timeout counter -> WAIT_ACK.
  - WAIT_ACK: if fsm_ready==0 -> WAIT_DONE. Otherwise increment the counter. When the counter reaches ACK_TIMEOUT-1 with fsm_ready still 1: pulse timeout_err, set rr_ptr=(grant_id+1) mod NUM_REQ, no req_done -> IDLE.
  - WAIT_DONE: when fsm_ready==1, pulse req_done[grant_id] for one cycle, set rr_ptr=(grant_id+1) mod NUM_REQ -> IDLE.
- Latency: the handshake edge is cycle 0 and fsm_start is high in cycle 1. The earliest next handshake is the cycle after the req_done pulse.
- fsm_addr/fsm_data are held stable from ISSUE until the next handshake. They are not cleared on completion.
- Requesters hold req_valid and payload until the handshake. Deasserting req_valid before the handshake is legal and has no effect.
- A req_valid change during ISSUE/WAIT_* is ignored until IDLE.
- rr_ptr wraps from NUM_REQ-1 to 0. Values >= NUM_REQ are never produced.
- A requester whose req_valid stays high after its done is only re-granted after all other pending requesters have been served (fairness).
- Reset mid-transfer aborts with no req_done or timeout_err. The i2c_fsm is expected to be reset by the same arst.

Test Plan:
1. Reset, then req_valid=4'b0100, addr 0x2A, data 0xC3, fsm_ready=1. Expect req_ready=4'b0100 that cycle, fsm_start pulse one cycle later with fsm_addr=0x2A and fsm_data=0xC3. Model drops fsm_ready for 20 cycles. Expect req_done[2] one cycle after fsm_ready rises and grant_id=2.
2. All four req_valid held high continuously. Expect grant order 0,1,2,3,0,1 with exactly one req_done per grant and no overlapping fsm_start.
3. rr_ptr=3 (after serving 2), req_valid=4'b1001. Expect grant 3, then grant 0 (wrap-around).
4. Model never drops fsm_ready after fsm_start. Expect timeout_err pulse exactly ACK_TIMEOUT=16 cycles after ISSUE, no req_done, return to IDLE with rr_ptr advanced.
5. fsm_ready=0 while req_valid=4'b0010. Expect req_ready=0 and no grant. Raise fsm_ready: grant occurs that cycle.
6. Assert arst low during WAIT_DONE. Expect busy, fsm_start, req_done and grant_id at 0 immediately, and no req_done after release.
